rsqrt_iteration_scheduler: RTL and testbench
============================================

// Module: rsqrt_iteration_scheduler
// PURPOSE
//  Shares one external newtons_method_rsqrt core among NUM_REQ requesters (round-robin) and sequences it.
//  Per accepted request: seeds a guess from x's leading-one position, issues up to max_iterations Newton steps,
//  stops early on convergence, returns 1/sqrt(x) tagged with requester id. One job in flight at a time.
// PARAMETERS
//  num_requesters   4   number of request ports (>=1); id width IW = max(1,$clog2(num_requesters))
//  frac_bits        16  fractional bits of ransac_fixed::fixed_t; seed math uses this
//  max_iterations   6   Newton steps cap per job (>=1); counter width $clog2(max_iterations+1)
//  tolerance        2   convergence threshold, LSBs of fixed_t: stop when |new-old| <= tolerance
// PORTS
//  clock            in   1          clock, rising edge
//  reset            in   1          reset, synchronous, active-high
//  req_valid        in   NR         per-requester request valid
//  req_number       in   NR x W     x per requester (fixed_t, W = ransac_fixed::value_bits())
//  req_ready        out  NR         one-hot grant; transfer when req_valid[i] && req_ready[i]
//  resp_valid       out  1          result valid; held until resp_ready
//  resp_ready       in   1          consumer accepts result
//  resp_id          out  IW         requester index of result
//  resp_result      out  W          1/sqrt(x), fixed_t
//  resp_error       out  1          x <= 0; resp_result = 0
//  resp_iterations  out  cnt        Newton steps actually run
//  core_input_valid out  1          to core input_valid
//  core_number      out  W          to core number
//  core_old_guess   out  W          to core old_guess
//  core_input_ready in   1          from core input_ready
//  core_output_valid in  1          from core output_valid
//  core_new_guess   in   W          from core new_guess
// BEHAVIOUR
//  Reset: state IDLE, req_ready=0, resp_valid=0, resp_error=0, core_input_valid=0, rr pointer=0, all data regs 0.
//  FSM: IDLE -> SEED -> ISSUE -> WAIT -> CHECK -> (ISSUE | RESPOND) -> IDLE.
//  IDLE: req_ready asserted combinationally only to the round-robin winner: first i with req_valid[i], scanning
//    from ptr upward, wrapping. On transfer latch x and id, ptr <= id+1 (mod NR), go SEED. No request: stay.
//  SEED (1 cycle): if x <= 0 (signed) -> RESPOND with error=1, result=0, iterations=0, no core access.
//    Else p = index of highest set bit, e = p - frac_bits, guess = 2^(-floor(e/2)) i.e. one() >> floor(e/2)
//    (left shift if negative, arithmetic floor), saturated to max positive fixed_t.
//  ISSUE: core_input_valid=1 with core_number=x, core_old_guess=guess; leave for WAIT on the first cycle
//    core_input_ready=1 (deasserting core_input_valid the next cycle).
//  WAIT: on core_output_valid capture core_new_guess, iter++ ; go CHECK. Ignore core_output_valid in other states.
//  CHECK (1 cycle): converged = |new-old| <= tolerance; guess <= new. If converged or iter==max_iterations
//    -> RESPOND; else -> ISSUE. Negative core output -> RESPOND with error=1, result=0.
//  RESPOND: resp_valid=1 with registered id/result/error/iterations, stable until resp_valid && resp_ready;
//    then IDLE. Simultaneous new req_valid does not get granted until back in IDLE (req_ready=0 outside IDLE).
//  Latency (no backpressure, core latency Lc): 1 (accept) +1 (SEED) + n*(issue+Lc+1) + 1 to resp_valid.
//  Reset mid-job: job dropped, no resp; core is reset by same signal. Requester must re-request.
//  Fairness: a continuously-requesting port waits at most NR-1 jobs.
// TESTING
//  1. req 0 x=4.0 (0x0004_0000) -> seed 0.5; resp_id=0, result=0x0000_8000, iterations=1 (converged).
//  2. x=2.0 -> result within 2 LSB of 0x0000_B505 (0.70711), iterations <= max_iterations, error=0.
//  3. x=0 and x=-1.0 -> resp_error=1, result=0, iterations=0, core_input_valid never asserted.
//  4. All 4 req_valid held high, 8 jobs -> grant order 0,1,2,3,0,1,2,3; resp_id matches; no starvation.
//  5. resp_ready low 10 cycles -> resp_valid/resp_* stable, no req_ready, no core activity; then 1 handshake.
//  6. Assert reset during WAIT -> next cycle all outputs at reset values; fresh request completes correctly.

Source files
------------

// File: rtl/rsqrt_iteration_scheduler.sv
// Round-robin front end and sequencer for one shared Newton reciprocal-square-root core.
// Seeds each job from the leading-one position of x, then iterates until converged or capped.
module rsqrt_iteration_scheduler #(
    parameter int num_requesters = 4,
    parameter int frac_bits      = 16,
    parameter int max_iterations = 6,
    parameter int tolerance      = 2,
    parameter int value_bits     = 32,
    localparam int NR = num_requesters,
    localparam int W  = value_bits,
    localparam int IW = (num_requesters > 1) ? $clog2(num_requesters) : 1,
    localparam int CW = $clog2(max_iterations + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NR-1:0]        req_valid,
    input  logic [NR-1:0][W-1:0] req_number,
    output logic [NR-1:0]        req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IW-1:0]        resp_id,
    output logic [W-1:0]         resp_result,
    output logic                 resp_error,
    output logic [CW-1:0]        resp_iterations,
    output logic                 core_input_valid,
    output logic [W-1:0]         core_number,
    output logic [W-1:0]         core_old_guess,
    input  logic                 core_input_ready,
    input  logic                 core_output_valid,
    input  logic [W-1:0]         core_new_guess
);
    localparam logic [W-1:0] ONE     = W'(1) << frac_bits;
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_ISSUE, S_WAIT, S_CHECK, S_RESPOND} state_t;
    state_t state, state_next;

    logic [IW-1:0] ptr, id_reg, grant_id;
    logic [NR-1:0] grant;
    logic          found;
    logic [W-1:0]  x_reg, guess, new_guess, result, seed;
    logic [CW-1:0] iter;
    logic          err;
    logic          x_nonpos, new_neg, converged, at_cap;
    logic signed [W:0] diff, abs_diff;
    int            idx, p, e, h, k;

    // Round-robin: first valid requester at or after ptr, wrapping.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int j = 0; j < NR; j++) begin
            idx = (int'(ptr) + j) % NR;
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IW'(idx);
            end
        end
    end

    // Seed 2^-floor(e/2); arithmetic shift gives floor for negative e.
    always_comb begin
        p    = 0;
        e    = 0;
        h    = 0;
        k    = 0;
        seed = '0;
        for (int i = 0; i < W; i++)
            if (x_reg[i]) p = i;
        e = p - frac_bits;
        h = e >>> 1;
        if (h >= 0) begin
            seed = ONE >> h;
        end else begin
            k = -h;
            if (frac_bits + k > W - 2) seed = MAX_POS;
            else                       seed = ONE << k;
        end
    end

    assign x_nonpos  = ($signed(x_reg) <= 0);
    assign new_neg   = new_guess[W-1];
    assign diff      = $signed({new_guess[W-1], new_guess}) - $signed({guess[W-1], guess});
    assign abs_diff  = (diff < 0) ? -diff : diff;
    assign converged = (abs_diff <= (W+1)'(tolerance));
    assign at_cap    = (iter == CW'(max_iterations));

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next       = state;
        req_ready        = '0;
        core_input_valid = 1'b0;
        resp_valid       = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = grant;
                if (found) state_next = S_SEED;
            end
            S_SEED:    state_next = x_nonpos ? S_RESPOND : S_ISSUE;
            S_ISSUE: begin
                core_input_valid = 1'b1;
                if (core_input_ready) state_next = S_WAIT;
            end
            S_WAIT:    if (core_output_valid) state_next = S_CHECK;
            S_CHECK:   state_next = (new_neg || converged || at_cap) ? S_RESPOND : S_ISSUE;
            S_RESPOND: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = S_IDLE;
            end
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr       <= '0;
            id_reg    <= '0;
            x_reg     <= '0;
            guess     <= '0;
            new_guess <= '0;
            result    <= '0;
            iter      <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (found) begin
                    x_reg  <= req_number[grant_id];
                    id_reg <= grant_id;
                    ptr    <= IW'((int'(grant_id) + 1) % NR);
                    iter   <= '0;
                    err    <= 1'b0;
                    result <= '0;
                end
                S_SEED: begin
                    if (x_nonpos) begin
                        err    <= 1'b1;
                        result <= '0;
                    end else begin
                        guess  <= seed;
                    end
                end
                S_WAIT: if (core_output_valid) begin
                    new_guess <= core_new_guess;
                    iter      <= iter + CW'(1);
                end
                S_CHECK: begin
                    guess <= new_guess;
                    if (new_neg) begin
                        err    <= 1'b1;
                        result <= '0;
                    end else if (converged || at_cap) begin
                        result <= new_guess;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_number     = x_reg;
    assign core_old_guess  = guess;
    assign resp_id         = id_reg;
    assign resp_result     = result;
    assign resp_error      = err;
    assign resp_iterations = iter;
endmodule

// File: tb/tb_rsqrt_iteration_scheduler.sv
// Bench for rsqrt_iteration_scheduler: behavioural Newton core with random latency/ready,
// directed and random jobs checked against a reference computed from x alone.
module tb_rsqrt_iteration_scheduler;
    localparam int NR = 4, W = 32, FB = 16, MAXI = 6, TOL = 2, IW = 2, CW = 3;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [NR-1:0]        req_valid = '0;
    logic [NR-1:0][W-1:0] req_number = '0;
    logic [NR-1:0]        req_ready;
    logic                 resp_valid;
    logic                 resp_ready = 1'b0;
    logic [IW-1:0]        resp_id;
    logic [W-1:0]         resp_result;
    logic                 resp_error;
    logic [CW-1:0]        resp_iterations;
    logic                 core_input_valid;
    logic [W-1:0]         core_number, core_old_guess;
    logic                 core_input_ready = 1'b0;
    logic                 core_output_valid = 1'b0;
    logic [W-1:0]         core_new_guess = '0;

    int total = 0, bad = 0;
    int civ_cycles = 0;

    rsqrt_iteration_scheduler #(.num_requesters(NR), .frac_bits(FB), .max_iterations(MAXI),
                                .tolerance(TOL), .value_bits(W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_number(req_number), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_error(resp_error), .resp_iterations(resp_iterations),
        .core_input_valid(core_input_valid), .core_number(core_number),
        .core_old_guess(core_old_guess), .core_input_ready(core_input_ready),
        .core_output_valid(core_output_valid), .core_new_guess(core_new_guess));

    always #5 clock = ~clock;

    // g' = g*(3 - x*g^2)/2 in fixed point
    function automatic logic [31:0] newton32(input logic [31:0] x, input logic [31:0] g);
        longint xl, gl, t, r;
        xl = longint'($signed(x));
        gl = longint'($signed(g));
        t  = (((xl * gl) >>> FB) * gl) >>> FB;
        t  = (longint'(3) <<< FB) - t;
        r  = ((gl * t) >>> FB) >>> 1;
        return r[31:0];
    endfunction

    // Behavioural core: random input_ready, 1..3 cycle latency, one op at a time.
    logic busy = 1'b0;
    int   cnt = 0;
    logic [31:0] pend = '0;
    always @(posedge clock) begin
        if (reset) begin
            busy              <= 1'b0;
            core_output_valid <= 1'b0;
            core_input_ready  <= 1'b0;
        end else begin
            core_input_ready  <= ($urandom_range(0, 3) != 0);
            core_output_valid <= 1'b0;
            if (busy) begin
                if (cnt == 0) begin
                    core_output_valid <= 1'b1;
                    core_new_guess    <= pend;
                    busy              <= 1'b0;
                end else cnt <= cnt - 1;
            end else if (core_input_valid && core_input_ready) begin
                busy <= 1'b1;
                cnt  <= $urandom_range(0, 2);
                pend <= newton32(core_number, core_old_guess);
            end
        end
        if (core_input_valid) civ_cycles <= civ_cycles + 1;
    end

    int          gq[$];
    logic [31:0] gx[$];
    int          rid[$], rit[$];
    logic [31:0] rres[$];
    logic        rerr[$];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && req_ready[i]) begin
                    gq.push_back(i);
                    gx.push_back(req_number[i]);
                end
            if (resp_valid && resp_ready) begin
                rid.push_back(int'(resp_id));
                rres.push_back(resp_result);
                rerr.push_back(resp_error);
                rit.push_back(int'(resp_iterations));
            end
        end
    end

    task automatic ref_job(input logic [31:0] x, output logic [31:0] res, output logic err,
                           output int it);
        longint g, n, d;
        int p, e, h;
        res = '0; err = 1'b0; it = 0;
        if ($signed(x) <= 0) begin err = 1'b1; return; end
        p = 0;
        for (int i = 0; i < 32; i++) if (x[i]) p = i;
        e = p - FB;
        h = (e >= 0) ? e / 2 : (e - 1) / 2;
        g = (h >= 0) ? (longint'(1) <<< FB) >>> h : (longint'(1) <<< FB) <<< (-h);
        if (g > 64'sh7FFF_FFFF) g = 64'sh7FFF_FFFF;
        for (int i = 1; i <= MAXI; i++) begin
            n  = longint'($signed(newton32(x, g[31:0])));
            it = i;
            if (n < 0) begin err = 1'b1; res = '0; return; end
            d = (n > g) ? n - g : g - n;
            if (d <= TOL || i == MAXI) begin res = n[31:0]; return; end
            g = n;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input int id, input string tag);
        bit got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            #1;
            if (req_ready[id]) got = 1;
            @(negedge clock);
        end
        req_valid[id] = 1'b0;
        check({tag, " grant"}, 64'(got), 64'd1);
    endtask

    task automatic wait_resp(input string tag, output bit got);
        got = 0;
        for (int c = 0; c < 500 && !got; c++) begin
            if (resp_valid) got = 1;
            else @(negedge clock);
        end
        check({tag, " resp timeout"}, 64'(got), 64'd1);
    endtask

    task automatic do_job(input int id, input logic [31:0] x, input string tag,
                          output logic [31:0] res);
        logic [31:0] er; logic ee; int ei; bit got;
        ref_job(x, er, ee, ei);
        res = 'x;
        @(negedge clock);
        req_valid[id] = 1'b1; req_number[id] = x;
        wait_grant(id, tag);
        wait_resp(tag, got);
        if (got) begin
            res = resp_result;
            check({tag, " id"},     64'(resp_id),         64'(id));
            check({tag, " result"}, 64'(resp_result),     64'(er));
            check({tag, " error"},  64'(resp_error),      64'(ee));
            check({tag, " iters"},  64'(resp_iterations), 64'(ei));
            resp_ready = 1'b1;
            @(negedge clock);
            resp_ready = 1'b0;
            check({tag, " resp drop"}, 64'(resp_valid), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] r, er, x5, civ0;
        logic ee;
        int ei, d;
        bit got;

        repeat (3) @(negedge clock);
        check("rst req_ready",  64'(req_ready),        64'd0);
        check("rst resp_valid", 64'(resp_valid),       64'd0);
        check("rst resp_error", 64'(resp_error),       64'd0);
        check("rst core_valid", 64'(core_input_valid), 64'd0);
        check("rst result",     64'(resp_result),      64'd0);
        reset = 1'b0;

        // x = 4.0 converges on the seed in one step
        do_job(0, 32'h0004_0000, "t1", r);
        check("t1 const result", 64'(r), 64'h8000);

        do_job(1, 32'h0002_0000, "t2", r);
        d = int'($signed(r)) - 32'hB505;
        check("t2 near 0.7071", 64'((d <= 2) && (d >= -2)), 64'd1);

        civ0 = civ_cycles;
        do_job(2, 32'h0000_0000, "t3 zero", r);
        do_job(3, 32'hFFFF_0000, "t3 neg", r);
        check("t3 no core access", 64'(civ_cycles), 64'(civ0));

        // All four requesting continuously; pointer starts back at 0
        gq.delete(); gx.delete(); rid.delete(); rres.delete(); rerr.delete(); rit.delete();
        @(negedge clock);
        for (int i = 0; i < NR; i++) begin
            req_number[i] = $urandom_range(1, 32'h00FF_FFFF);
            req_valid[i]  = 1'b1;
        end
        resp_ready = 1'b1;
        for (int c = 0; c < 4000 && rid.size() < 8; c++) begin
            #1;
            check("t4 onehot", 64'($onehot0(req_ready)), 64'd1);
            @(negedge clock);
        end
        req_valid  = '0;
        resp_ready = 1'b0;
        check("t4 resp count", 64'(rid.size() >= 8), 64'd1);
        if (rid.size() >= 8 && gq.size() >= 8) begin
            for (int j = 0; j < 8; j++) begin
                ref_job(gx[j], er, ee, ei);
                check($sformatf("t4 grant %0d", j), 64'(gq[j]),   64'(j % NR));
                check($sformatf("t4 rid %0d", j),   64'(rid[j]),  64'(gq[j]));
                check($sformatf("t4 res %0d", j),   64'(rres[j]), 64'(er));
                check($sformatf("t4 err %0d", j),   64'(rerr[j]), 64'(ee));
                check($sformatf("t4 it %0d", j),    64'(rit[j]),  64'(ei));
            end
        end

        for (int j = 0; j < 12; j++) begin
            int id, sel;
            logic [31:0] x;
            id  = $urandom_range(0, NR - 1);
            sel = $urandom_range(0, 5);
            if (sel == 0)      x = $urandom_range(1, 255);
            else if (sel == 1) x = {1'b1, 31'($urandom)};
            else               x = $urandom_range(1, 32'h00FF_FFFF);
            do_job(id, x, $sformatf("rand%0d", j), r);
        end

        // Backpressure: response must hold while other requesters wait
        x5 = 32'h0009_0000;
        ref_job(x5, er, ee, ei);
        @(negedge clock);
        req_valid[1] = 1'b1; req_number[1] = x5;
        wait_grant(1, "t5");
        req_valid = 4'b1101;
        wait_resp("t5", got);
        civ0 = civ_cycles;
        for (int c = 0; c < 10 && got; c++) begin
            #1;
            check("t5 valid",     64'(resp_valid),       64'd1);
            check("t5 id",        64'(resp_id),          64'd1);
            check("t5 result",    64'(resp_result),      64'(er));
            check("t5 iters",     64'(resp_iterations),  64'(ei));
            check("t5 req_ready", 64'(req_ready),        64'd0);
            check("t5 core",      64'(core_input_valid), 64'd0);
            @(negedge clock);
        end
        check("t5 no core cycles", 64'(civ_cycles), 64'(civ0));
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        req_valid  = '0;
        check("t5 released", 64'(resp_valid), 64'd0);

        // Reset while waiting on the core drops the job
        @(negedge clock);
        req_valid[2] = 1'b1; req_number[2] = 32'h0003_0000;
        wait_grant(2, "t6");
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (core_input_valid && core_input_ready) got = 1;
            else @(negedge clock);
        end
        check("t6 issue seen", 64'(got), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6 req_ready", 64'(req_ready),        64'd0);
        check("t6 resp_valid",64'(resp_valid),       64'd0);
        check("t6 resp_error",64'(resp_error),       64'd0);
        check("t6 core",      64'(core_input_valid), 64'd0);
        check("t6 result",    64'(resp_result),      64'd0);
        check("t6 iters",     64'(resp_iterations),  64'd0);
        check("t6 id",        64'(resp_id),          64'd0);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            check("t6 dropped", 64'(resp_valid | core_input_valid), 64'd0);
        end
        do_job(2, 32'h0003_0000, "t6 fresh", r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
